// File: rtl/mux_pkg.sv
// mux_pkg: shared mode constants and channel unpack helper for the N-way mux
package mux_pkg;
  localparam logic MUX_MODE_SEL = 1'b0;
  localparam logic MUX_MODE_RR = 1'b1;
  localparam int MUX_MAX_BUS = 1024;
  // Callers cast the result down to their channel width.
  function automatic logic [MUX_MAX_BUS-1:0] mux_chan(input logic [MUX_MAX_BUS-1:0] bus, input int i, input int w);
    return bus >> (i * w);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, scanning from ptr+1 modulo N
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_vld
);
  // Scan farthest-first so the nearest requester after ptr is written last.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = N; k >= 1; k--) begin
      int j;
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        gnt_idx = W'(j);
        gnt_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_nway_reg.sv
// mux_nway_reg: N-way select/round-robin mux into a one-entry registered output stage
// Optional out_parity port enabled by MUX_NWAY_PARITY_EN.
module mux_nway_reg
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef MUX_NWAY_PARITY_EN
  ,output logic                   out_parity
`endif
);
  logic [SEL_W-1:0] rr_ptr, rr_idx, grant;
  logic rr_vld, sel_ok, gnt_vld, load_en, xfer;
  logic [WIDTH-1:0] chan;
  rr_arbiter #(.N(NUM_IN)) u_arb (
    .req(in_valid),
    .ptr(rr_ptr),
    .gnt_idx(rr_idx),
    .gnt_vld(rr_vld)
  );
  // Range guard keeps an out-of-range sel from indexing past in_valid.
  assign sel_ok = (int'(sel) < NUM_IN) ? in_valid[sel] : 1'b0;
  assign grant = (mode == MUX_MODE_RR) ? rr_idx : sel;
  assign gnt_vld = (mode == MUX_MODE_RR) ? rr_vld : sel_ok;
  assign load_en = !out_valid || out_ready;
  assign xfer = gnt_vld && load_en;
  assign in_ready = (rst_n && xfer) ? NUM_IN'(1) << grant : '0;
  assign chan = WIDTH'(mux_chan(MUX_MAX_BUS'(in_data), int'(grant), WIDTH));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_src <= '0;
      rr_ptr <= SEL_W'(NUM_IN - 1);
    end else begin
      if (xfer) begin
        out_data <= chan;
        out_src <= grant;
        out_valid <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
      if (xfer && mode == MUX_MODE_RR) rr_ptr <= grant;
    end
  end
`ifdef MUX_NWAY_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_parity <= 1'b0;
    else if (xfer) out_parity <= ^chan;
  end
`endif
endmodule

// File: tb/tb_mux_nway_reg.sv
// tb_mux_nway_reg: directed checks of select, round-robin, backpressure, reset and a 3-input instance
module tb_mux_nway_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0] in_valid = '0, in_ready;
  logic mode = 1'b0, out_valid, out_ready = 1'b0;
  logic [1:0] sel = '0, out_src;
  logic [7:0] out_data;
  logic [23:0] in_data3 = '0;
  logic [2:0] in_valid3 = '0, in_ready3;
  logic mode3 = 1'b0, out_valid3, out_ready3 = 1'b0;
  logic [1:0] sel3 = '0, out_src3;
  logic [7:0] out_data3;
  int pass_cnt = 0, total = 0;
`ifdef MUX_NWAY_PARITY_EN
  logic out_parity, out_parity3;
`endif
  always #5 clk = ~clk;
  mux_nway_reg #(.WIDTH(8), .NUM_IN(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef MUX_NWAY_PARITY_EN
    , .out_parity(out_parity)
`endif
  );
  mux_nway_reg #(.WIDTH(8), .NUM_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(mode3), .sel(sel3), .out_data(out_data3), .out_src(out_src3), .out_valid(out_valid3),
    .out_ready(out_ready3)
`ifdef MUX_NWAY_PARITY_EN
    , .out_parity(out_parity3)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_data = $urandom;
    in_valid = 4'($urandom);
    mode = 1'($urandom);
    sel = 2'($urandom);
    out_ready = 1'($urandom);
    repeat (3) tick();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0h want 0", out_valid); else pass_cnt++;
    total++; if (out_data !== 8'h00) $display("FAIL reset_data got %0h want 0", out_data); else pass_cnt++;
    total++; if (out_src !== 2'd0) $display("FAIL reset_src got %0h want 0", out_src); else pass_cnt++;
    total++; if (in_ready !== 4'b0000) $display("FAIL reset_in_ready got %0h want 0", in_ready); else pass_cnt++;
    rst_n = 1'b1;
    mode = 1'b1;
    in_valid = 4'hF;
    out_ready = 1'b1;
    in_data = 32'h44332211;
    tick();
    total++; if (out_src !== 2'd0) $display("FAIL reset_first_rr_src got %0h want 0", out_src); else pass_cnt++;
    total++; if (out_data !== 8'h11) $display("FAIL reset_first_rr_data got %0h want 11", out_data); else pass_cnt++;
  endtask

  task automatic test_select;
    mode = 1'b0;
    sel = 2'd2;
    in_data = 32'h00A50000;
    in_valid = 4'b0100;
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0100) $display("FAIL sel_in_ready got %0h want 4", in_ready); else pass_cnt++;
    tick();
    total++; if (out_data !== 8'hA5) $display("FAIL sel_data got %0h want a5", out_data); else pass_cnt++;
    total++; if (out_src !== 2'd2) $display("FAIL sel_src got %0h want 2", out_src); else pass_cnt++;
    total++; if (out_valid !== 1'b1) $display("FAIL sel_valid got %0h want 1", out_valid); else pass_cnt++;
    sel = 2'd1;
    #1;
    total++; if (in_ready !== 4'b0000) $display("FAIL sel_invalid_ready got %0h want 0", in_ready); else pass_cnt++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL sel_invalid_drain got %0h want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_round_robin;
    logic [31:0] d;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    d = 32'hD4C3B2A1;
    in_data = d;
    mode = 1'b1;
    in_valid = 4'hF;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      total++; if (out_src !== 2'(k % 4) || out_valid !== 1'b1) $display("FAIL rr_all_src[%0d] got %0h want %0h", k, out_src, k % 4); else pass_cnt++;
      total++; if (out_data !== d[(k % 4) * 8 +: 8]) $display("FAIL rr_all_data[%0d] got %0h want %0h", k, out_data, d[(k % 4) * 8 +: 8]); else pass_cnt++;
    end
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (out_src !== ((k % 2 == 1) ? 2'd3 : 2'd1)) $display("FAIL rr_alt_src[%0d] got %0h want %0h", k, out_src, (k % 2 == 1) ? 3 : 1); else pass_cnt++;
    end
  endtask

  task automatic test_backpressure;
    in_valid = 4'hF;
    in_data = 32'h44332A3C;
    tick();
    total++; if (out_data !== 8'h3C || out_src !== 2'd0) $display("FAIL bp_load got %0h/%0h want 3c/0", out_data, out_src); else pass_cnt++;
    out_ready = 1'b0;
    in_data = 32'h998877EE;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (in_ready !== 4'b0000) $display("FAIL bp_in_ready[%0d] got %0h want 0", k, in_ready); else pass_cnt++;
      tick();
      total++; if (out_data !== 8'h3C || out_src !== 2'd0 || out_valid !== 1'b1) $display("FAIL bp_hold[%0d] got %0h/%0h want 3c/0", k, out_data, out_src); else pass_cnt++;
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0010) $display("FAIL bp_release_ready got %0h want 2", in_ready); else pass_cnt++;
    tick();
    total++; if (out_src !== 2'd1 || out_data !== 8'h77) $display("FAIL bp_release_load got %0h/%0h want 1/77", out_src, out_data); else pass_cnt++;
  endtask

  task automatic test_non_pow2;
    mode3 = 1'b0;
    sel3 = 2'd3;
    in_valid3 = 3'b111;
    out_ready3 = 1'b1;
    in_data3 = 24'hCCBBAA;
    #1;
    total++; if (in_ready3 !== 3'b000) $display("FAIL np2_sel3_ready got %0h want 0", in_ready3); else pass_cnt++;
    tick();
    total++; if (out_valid3 !== 1'b0) $display("FAIL np2_sel3_valid got %0h want 0", out_valid3); else pass_cnt++;
    mode3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (out_src3 !== 2'(k % 3) || out_valid3 !== 1'b1) $display("FAIL np2_rr_src[%0d] got %0h want %0h", k, out_src3, k % 3); else pass_cnt++;
    end
  endtask

  task automatic test_mid_reset;
    out_ready = 1'b0;
    mode = 1'b1;
    in_valid = 4'hF;
    in_data = 32'h44332211;
    #1;
    total++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid got %0h want 1", out_valid); else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_data !== 8'h00) $display("FAIL mid_async_clear got %0h/%0h want 0/0", out_valid, out_data); else pass_cnt++;
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    total++; if (out_src !== 2'd0 || out_data !== 8'h11) $display("FAIL mid_first_rr got %0h/%0h want 0/11", out_src, out_data); else pass_cnt++;
`ifdef MUX_NWAY_PARITY_EN
    mode = 1'b0;
    sel = 2'd0;
    in_data = 32'h00000007;
    tick();
    total++; if (out_parity !== 1'b1) $display("FAIL parity_07 got %0h want 1", out_parity); else pass_cnt++;
    in_data = 32'h00000003;
    tick();
    total++; if (out_parity !== 1'b0) $display("FAIL parity_03 got %0h want 0", out_parity); else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_select();
    test_round_robin();
    test_backpressure();
    test_non_pow2();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/mux_nway_reg.md
Name: mux_nway_reg

Overview:
- Parametrised successor to the 8-bit 2:1 data mux. Selects one of NUM_IN channels of WIDTH bits and registers the winner into a one-entry output stage, with a valid/ready handshake on every side.
- Two selection modes: explicit select and round-robin arbitration.
- Sits in the datapath wherever several producers share one consumer, e.g. writeback source select or shared-bus arbitration. Replaces chains of 2:1 muxes.

Parameters:
- WIDTH, 8, data width of each channel and of the output.
- NUM_IN, 4, number of input channels (>= 2; need not be a power of 2).
- SEL_W, $clog2(NUM_IN), derived select/index width (localparam, not overridable).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_IN*WIDTH  packed channel data; channel i at [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready; at most one bit high per cycle.
- mode  input  1  0 = explicit select, 1 = round-robin.
- sel  input  SEL_W  channel index, used only when mode=0.
- out_data  output  WIDTH  registered selected data.
- out_src  output  SEL_W  index of the channel that produced out_data.
- out_valid  output  1  output register holds valid data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (async assert, sync-safe deassert): out_valid=0, out_data=0, out_src=0, rr_ptr=NUM_IN-1, so the first round-robin grant favours channel 0.
- load_en = !out_valid || out_ready. The stage is full-throughput: a new word can load in the same cycle the old one drains.
- Grant (combinational, one channel or none):
  - mode=0: grant = sel when sel < NUM_IN and in_valid[sel]=1; otherwise no grant. An out-of-range sel never grants and never X-propagates.
  - mode=1: grant = first i with in_valid[i]=1, scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_IN.
- in_ready[i] = load_en && grant==i. Channel i transfers when in_valid[i] && in_ready[i].
- in_ready does not depend on in_valid of other channels beyond the grant decision. It never depends on out_data.
- On a transfer at edge t: out_data <= in_data[grant], out_src <= grant, out_valid <= 1, visible from t+1. Latency is 1 cycle.
- If out_ready=1 and there is no transfer, out_valid <= 0. If out_ready=0 and out_valid=1, out_data and out_src hold stable.
- rr_ptr <= grant only on a transfer in mode=1. rr_ptr holds in mode=0 and on stalls.
- A mode or sel change takes effect on the next cycle's grant. rr_ptr is retained across mode changes.
- No input valid: no transfer; output drains normally.
- Reset asserted mid-operation: the output word is discarded immediately (out_valid=0) and rr_ptr returns to NUM_IN-1.

Optional Feature:
- Macro: MUX_NWAY_PARITY_EN.
- Defined:
  - Extra output port out_parity (1 bit) = XOR-reduce of the data loaded, registered alongside out_data.
  - Resets to 0 and holds with out_data during a stall.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package mux_pkg:
  - mode constants MUX_MODE_SEL=1'b0, MUX_MODE_RR=1'b1;
  - a function that unpacks channel i from a packed bus.
- One sub-module, rr_arbiter:
  - parameter N;
  - ports req[N-1:0], ptr[$clog2(N)-1:0], gnt_idx, gnt_vld;
  - purely combinational, instantiated once.
- Pointer register, explicit-select path and output stage stay in mux_nway_reg.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> out_valid=0, out_data=0, out_src=0, in_ready=0. Release, then mode=1 with all valid -> first out_src=0.
- Explicit select, WIDTH=8, NUM_IN=4: mode=0, sel=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100. Next cycle out_data=8'hA5, out_src=2, out_valid=1. Repeat with sel=1 and ch1 invalid -> no grant, out_valid drops.
- Round-robin fairness: mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3 with one transfer per cycle. Then in_valid=4'b1010 -> alternates 1,3.
- Backpressure: out_valid=1 with out_data=8'h3C, out_ready=0 for 3 cycles, all inputs valid -> in_ready=0, out_data/out_src stable, rr_ptr unchanged. Raise out_ready -> next channel after the held one loads the same cycle.
- Non-power-of-2: NUM_IN=3, mode=0, sel=3 with all valid -> in_ready=0, no transfer. mode=1 -> rotation 0,1,2,0.
- Mid-operation reset: with out_valid=1 and out_ready=0, pulse rst_n low for less than a cycle -> out_valid=0 immediately. After release, the first round-robin grant is channel 0. With MUX_NWAY_PARITY_EN, out_data=8'h07 -> out_parity=1.
